// File: rtl/pc_pkg.sv
// ============================================================================
// Module      : pc_pkg
// Description : Shared types and default constants for the PC sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pc_pkg;

    localparam int          PC_INC       = 4;
    localparam logic [31:0] PC_RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] PC_EXC_VEC   = 32'h0000_0180;

    typedef enum logic [2:0] {
        SRC_SEQ  = 3'd0,
        SRC_BR   = 3'd1,
        SRC_J    = 3'd2,
        SRC_JR   = 3'd3,
        SRC_PEND = 3'd4,
        SRC_EXC  = 3'd5,
        SRC_ERET = 3'd6,
        SRC_HOLD = 3'd7
    } pc_src_e;

    typedef enum logic [0:0] {
        PEND_IDLE = 1'b0,
        PEND_FULL = 1'b1
    } pend_state_e;

endpackage : pc_pkg

`default_nettype wire

// File: rtl/pc_target_calc.sv
// ============================================================================
// Module      : pc_target_calc
// Description : Combinational branch / jump / jump-register target selection.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_target_calc
    import pc_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int INC    = PC_INC
) (
    input  logic [ADDR_W-1:0] inRedirBasePC,
    input  logic              inBranchTaken,
    input  logic [15:0]       inBranchImm,
    input  logic              inJump,
    input  logic [25:0]       inJumpIdx,
    input  logic              inJumpReg,
    input  logic [ADDR_W-1:0] inJumpRegTarget,
    output logic              outRedirect,
    output logic [ADDR_W-1:0] outTarget,
    output pc_src_e           outSrc,
    output logic              outMisalign
);

    logic [ADDR_W-1:0] w_base;
    logic [ADDR_W-1:0] w_branchOffset;
    logic [ADDR_W-1:0] w_branchTarget;
    logic [ADDR_W-1:0] w_jumpTarget;

    assign w_base         = inRedirBasePC + ADDR_W'(INC);
    assign w_branchOffset = {{(ADDR_W-18){inBranchImm[15]}}, inBranchImm, 2'b00};
    assign w_branchTarget = w_base + w_branchOffset;

    // A 28-bit PC has no region bits above the jump index to carry over.
    generate
        if (ADDR_W > 28) begin : g_jumpRegion
            assign w_jumpTarget = {w_base[ADDR_W-1:28], inJumpIdx, 2'b00};
        end else begin : g_jumpFlat
            assign w_jumpTarget = {inJumpIdx, 2'b00};
        end
    endgenerate

    assign outMisalign = inJumpReg && (inJumpRegTarget[1:0] != 2'b00);

    always_comb begin
        outRedirect = 1'b0;
        outTarget   = w_branchTarget;
        outSrc      = SRC_SEQ;
        if (inJumpReg) begin
            // A misaligned JR is not a redirect; the top turns it into a trap.
            outRedirect = !outMisalign;
            outTarget   = inJumpRegTarget;
            outSrc      = SRC_JR;
        end else if (inJump) begin
            outRedirect = 1'b1;
            outTarget   = w_jumpTarget;
            outSrc      = SRC_J;
        end else if (inBranchTaken) begin
            outRedirect = 1'b1;
            outTarget   = w_branchTarget;
            outSrc      = SRC_BR;
        end
    end

endmodule : pc_target_calc

`default_nettype wire

// File: rtl/pc_sequencer.sv
// ============================================================================
// Module      : pc_sequencer
// Description : Program counter with prioritised next-PC select, EPC and a
//               one-entry pending-redirect buffer for stalled fetch.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pc_sequencer
    import pc_pkg::*;
#(
    parameter int          ADDR_W    = 32,
    parameter int          INC       = PC_INC,
    parameter logic [31:0] RESET_VEC = PC_RESET_VEC,
    parameter logic [31:0] EXC_VEC   = PC_EXC_VEC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              inStall,
    input  logic              inBranchTaken,
    input  logic [15:0]       inBranchImm,
    input  logic              inJump,
    input  logic [25:0]       inJumpIdx,
    input  logic              inJumpReg,
    input  logic [ADDR_W-1:0] inJumpRegTarget,
    input  logic [ADDR_W-1:0] inRedirBasePC,
    input  logic              inException,
    input  logic [ADDR_W-1:0] inExcPC,
    input  logic              inEret,
    output logic [ADDR_W-1:0] outPC,
    output logic [ADDR_W-1:0] outPCPlus,
    output logic [ADDR_W-1:0] outEPC,
    output logic              outPendValid,
    output logic              outMisalign
);

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_epc;
    logic [ADDR_W-1:0] r_pendTarget;
    pend_state_e       r_state;

    logic              w_redirect;
    logic [ADDR_W-1:0] w_redirTarget;
    pc_src_e           w_redirSrc;
    logic              w_misalign;

    pc_src_e           w_src;
    logic [ADDR_W-1:0] w_nextPc;
    logic [ADDR_W-1:0] w_nextEpc;
    logic [ADDR_W-1:0] w_nextPendTarget;
    pend_state_e       w_nextState;

    pc_target_calc #(
        .ADDR_W (ADDR_W),
        .INC    (INC)
    ) u_targetCalc (
        .inRedirBasePC   (inRedirBasePC),
        .inBranchTaken   (inBranchTaken),
        .inBranchImm     (inBranchImm),
        .inJump          (inJump),
        .inJumpIdx       (inJumpIdx),
        .inJumpReg       (inJumpReg),
        .inJumpRegTarget (inJumpRegTarget),
        .outRedirect     (w_redirect),
        .outTarget       (w_redirTarget),
        .outSrc          (w_redirSrc),
        .outMisalign     (w_misalign)
    );

    always_comb begin
        w_src            = SRC_HOLD;
        w_nextEpc        = r_epc;
        w_nextPendTarget = r_pendTarget;
        w_nextState      = r_state;
        if (inException || w_misalign) begin
            w_src       = SRC_EXC;
            w_nextEpc   = inException ? inExcPC : inRedirBasePC;
            w_nextState = PEND_IDLE;
        end else if (inEret) begin
            w_src       = SRC_ERET;
            w_nextState = PEND_IDLE;
        end else if (w_redirect && !inStall) begin
            w_src       = w_redirSrc;
            w_nextState = PEND_IDLE;
        end else if (w_redirect) begin
            // Stalled redirect parks in the buffer; a newer one overwrites it.
            w_nextPendTarget = w_redirTarget;
            w_nextState      = PEND_FULL;
        end else if (!inStall && r_state == PEND_FULL) begin
            w_src       = SRC_PEND;
            w_nextState = PEND_IDLE;
        end else if (!inStall) begin
            w_src = SRC_SEQ;
        end
    end

    always_comb begin
        w_nextPc = r_pc;
        case (w_src)
            SRC_SEQ:                 w_nextPc = r_pc + ADDR_W'(INC);
            SRC_BR, SRC_J, SRC_JR:   w_nextPc = w_redirTarget;
            SRC_PEND:                w_nextPc = r_pendTarget;
            SRC_EXC:                 w_nextPc = EXC_VEC[ADDR_W-1:0];
            SRC_ERET:                w_nextPc = r_epc;
            default:                 w_nextPc = r_pc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc         <= RESET_VEC[ADDR_W-1:0];
            r_epc        <= '0;
            r_pendTarget <= '0;
            r_state      <= PEND_IDLE;
        end else begin
            r_pc         <= w_nextPc;
            r_epc        <= w_nextEpc;
            r_pendTarget <= w_nextPendTarget;
            r_state      <= w_nextState;
        end
    end

    assign outPC        = r_pc;
    assign outPCPlus    = r_pc + ADDR_W'(INC);
    assign outEPC       = r_epc;
    assign outPendValid = (r_state == PEND_FULL);
    assign outMisalign  = w_misalign;

endmodule : pc_sequencer

`default_nettype wire

// File: tb/tb_pc_sequencer.sv
// ============================================================================
// Module      : tb_pc_sequencer
// Description : Vector-table and scoreboard bench for pc_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pc_sequencer;

    logic        clk;
    logic        rst_n;
    logic        inStall;
    logic        inBranchTaken;
    logic [15:0] inBranchImm;
    logic        inJump;
    logic [25:0] inJumpIdx;
    logic        inJumpReg;
    logic [31:0] inJumpRegTarget;
    logic [31:0] inRedirBasePC;
    logic        inException;
    logic [31:0] inExcPC;
    logic        inEret;
    logic [31:0] outPC;
    logic [31:0] outPCPlus;
    logic [31:0] outEPC;
    logic        outPendValid;
    logic        outMisalign;

    int nTests = 0;
    int nFail  = 0;

    typedef struct {
        logic        rstn;
        logic        stall;
        logic        br;
        logic [15:0] imm;
        logic        j;
        logic [25:0] idx;
        logic        jr;
        logic [31:0] jrt;
        logic [31:0] base;
        logic        exc;
        logic [31:0] excPc;
        logic        eret;
        logic [31:0] expPc;
        logic [31:0] expEpc;
        logic        expPend;
        logic        expMis;
    } vec_t;

    vec_t tbl[$];
    vec_t sb[$];

    pc_sequencer u_dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .inStall         (inStall),
        .inBranchTaken   (inBranchTaken),
        .inBranchImm     (inBranchImm),
        .inJump          (inJump),
        .inJumpIdx       (inJumpIdx),
        .inJumpReg       (inJumpReg),
        .inJumpRegTarget (inJumpRegTarget),
        .inRedirBasePC   (inRedirBasePC),
        .inException     (inException),
        .inExcPC         (inExcPC),
        .inEret          (inEret),
        .outPC           (outPC),
        .outPCPlus       (outPCPlus),
        .outEPC          (outEPC),
        .outPendValid    (outPendValid),
        .outMisalign     (outMisalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(
        logic rstn, logic stall, logic br, logic [15:0] imm, logic j, logic [25:0] idx,
        logic jr, logic [31:0] jrt, logic [31:0] base, logic exc, logic [31:0] excPc,
        logic eret, logic [31:0] expPc, logic [31:0] expEpc, logic expPend, logic expMis);
        vec_t v;
        v.rstn = rstn; v.stall = stall; v.br = br; v.imm = imm; v.j = j; v.idx = idx;
        v.jr = jr; v.jrt = jrt; v.base = base; v.exc = exc; v.excPc = excPc; v.eret = eret;
        v.expPc = expPc; v.expEpc = expEpc; v.expPend = expPend; v.expMis = expMis;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    // Drive one vector, check the combinational flag, then score the edge.
    task automatic applyVec(input vec_t v, input string name);
        vec_t e;
        @(negedge clk);
        rst_n           = v.rstn;
        inStall         = v.stall;
        inBranchTaken   = v.br;
        inBranchImm     = v.imm;
        inJump          = v.j;
        inJumpIdx       = v.idx;
        inJumpReg       = v.jr;
        inJumpRegTarget = v.jrt;
        inRedirBasePC   = v.base;
        inException     = v.exc;
        inExcPC         = v.excPc;
        inEret          = v.eret;
        #1;
        chk({name, ".misalign"}, {31'd0, outMisalign}, {31'd0, v.expMis});
        sb.push_back(v);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({name, ".pc"},      outPC,     e.expPc);
        chk({name, ".pcPlus"},  outPCPlus, e.expPc + 32'd4);
        chk({name, ".epc"},     outEPC,    e.expEpc);
        chk({name, ".pend"},    {31'd0, outPendValid}, {31'd0, e.expPend});
    endtask

    initial begin
        rst_n = 1'b0; inStall = 1'b0; inBranchTaken = 1'b0; inBranchImm = '0;
        inJump = 1'b0; inJumpIdx = '0; inJumpReg = 1'b0; inJumpRegTarget = '0;
        inRedirBasePC = '0; inException = 1'b0; inExcPC = '0; inEret = 1'b0;

        //             rst st br imm       j  idx     jr jrt           base          ex excPc  er  expPc         epc      pnd mis
        tbl.push_back(mk(0, 0, 0, 16'h0,    0, 26'h0,  0, 32'h0,        32'h0,        0, 32'h0, 0, 32'h0,        32'h0,   0, 0));
        tbl.push_back(mk(1, 0, 0, 16'h0,    0, 26'h0,  0, 32'h0,        32'h0,        0, 32'h0, 0, 32'h4,        32'h0,   0, 0));
        tbl.push_back(mk(1, 0, 0, 16'h0,    0, 26'h0,  0, 32'h0,        32'h0,        0, 32'h0, 0, 32'h8,        32'h0,   0, 0));
        tbl.push_back(mk(1, 0, 1, 16'hFFFE, 0, 26'h0,  0, 32'h0,        32'h100,      0, 32'h0, 0, 32'h0FC,      32'h0,   0, 0));
        tbl.push_back(mk(1, 0, 1, 16'h0003, 0, 26'h0,  0, 32'h0,        32'h100,      0, 32'h0, 0, 32'h110,      32'h0,   0, 0));
        tbl.push_back(mk(1, 0, 0, 16'h0,    0, 26'h0,  0, 32'h0,        32'h0,        0, 32'h0, 0, 32'h114,      32'h0,   0, 0));
        tbl.push_back(mk(1, 0, 0, 16'h0,    0, 26'h0,  1, 32'h2002,     32'h200,      0, 32'h0, 0, 32'h180,      32'h200, 0, 1));
        tbl.push_back(mk(1, 0, 0, 16'h0,    0, 26'h0,  0, 32'h0,        32'h0,        0, 32'h0, 0, 32'h184,      32'h200, 0, 0));
        tbl.push_back(mk(1, 0, 0, 16'h0,    0, 26'h0,  1, 32'h2000,     32'h184,      0, 32'h0, 0, 32'h2000,     32'h200, 0, 0));
        tbl.push_back(mk(1, 0, 1, 16'h5,    1, 26'h10, 1, 32'h3000,     32'h2000,     0, 32'h0, 0, 32'h3000,     32'h200, 0, 0));
        tbl.push_back(mk(1, 0, 1, 16'h5,    1, 26'h10, 0, 32'h0,        32'h3000,     0, 32'h0, 0, 32'h40,       32'h200, 0, 0));
        tbl.push_back(mk(1, 0, 0, 16'h0,    1, 26'h1,  0, 32'h0,        32'hF000_0000,0, 32'h0, 0, 32'hF000_0004,32'h200, 0, 0));
        tbl.push_back(mk(1, 0, 0, 16'h0,    0, 26'h0,  1, 32'hFFFF_FFFC,32'h0,        0, 32'h0, 0, 32'hFFFF_FFFC,32'h200, 0, 0));
        tbl.push_back(mk(1, 0, 0, 16'h0,    0, 26'h0,  0, 32'h0,        32'h0,        0, 32'h0, 0, 32'h0,        32'h200, 0, 0));
        tbl.push_back(mk(1, 0, 0, 16'h0,    0, 26'h0,  0, 32'h0,        32'h0,        0, 32'h0, 0, 32'h4,        32'h200, 0, 0));

        foreach (tbl[i]) applyVec(tbl[i], $sformatf("vec%0d", i));

        // Jump raised during a three-cycle stall lands on release.
        applyVec(mk(1, 1, 0, 16'h0, 1, 26'h40, 0, 32'h0, 32'h0040_0000, 0, 32'h0, 0, 32'h4, 32'h200, 1, 0), "stallJ");
        for (int k = 0; k < 2; k++)
            applyVec(mk(1, 1, 0, 16'h0, 0, 26'h0, 0, 32'h0, 32'h0, 0, 32'h0, 0, 32'h4, 32'h200, 1, 0), $sformatf("stallHold%0d", k));
        applyVec(mk(1, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0, 32'h0, 0, 32'h0, 0, 32'h100, 32'h200, 0, 0), "stallRelease");

        // Exception under stall with pending valid, then return.
        applyVec(mk(1, 1, 1, 16'h0, 0, 26'h0, 0, 32'h0, 32'h180, 0, 32'h0,   0, 32'h100, 32'h200, 1, 0), "excPend");
        applyVec(mk(1, 1, 0, 16'h0, 0, 26'h0, 0, 32'h0, 32'h0,   1, 32'h500, 0, 32'h180, 32'h500, 0, 0), "excStall");
        applyVec(mk(1, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0, 32'h0,   0, 32'h0,   0, 32'h184, 32'h500, 0, 0), "excSeq");
        applyVec(mk(1, 0, 0, 16'h0, 0, 26'h0, 0, 32'h0, 32'h0,   0, 32'h0,   1, 32'h500, 32'h500, 0, 0), "eret");

        // Reset while stalled with a pending redirect.
        applyVec(mk(1, 1, 0, 16'h0, 1, 26'h40, 0, 32'h0, 32'h0, 0, 32'h0, 0, 32'h500, 32'h500, 1, 0), "rstPend");
        applyVec(mk(0, 1, 0, 16'h0, 1, 26'h40, 0, 32'h0, 32'h0, 0, 32'h0, 0, 32'h0,   32'h0,   0, 0), "rstMid");

        // Newer stalled redirect overwrites the buffer; eret ignores stall; trap beats misalign.
        applyVec(mk(1, 1, 0, 16'h0, 1, 26'h10, 0, 32'h0, 32'h0,   0, 32'h0,   0, 32'h0,   32'h0,   1, 0), "ovrJ");
        applyVec(mk(1, 1, 1, 16'h1, 0, 26'h0,  0, 32'h0, 32'h0,   0, 32'h0,   0, 32'h0,   32'h0,   1, 0), "ovrBr");
        applyVec(mk(1, 0, 0, 16'h0, 0, 26'h0,  0, 32'h0, 32'h0,   0, 32'h0,   0, 32'h8,   32'h0,   0, 0), "ovrRelease");
        applyVec(mk(1, 1, 0, 16'h0, 0, 26'h0,  0, 32'h0, 32'h0,   0, 32'h0,   1, 32'h0,   32'h0,   0, 0), "eretStall");
        applyVec(mk(1, 0, 0, 16'h0, 0, 26'h0,  1, 32'h1, 32'h900, 1, 32'h700, 0, 32'h180, 32'h700, 0, 1), "excMis");

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule : tb_pc_sequencer

`default_nettype wire
